// File: rtl/ad5791_cfg_sequencer_if.sv
// Configuration-side link between the sequencer and the AD5791 SPI serializer.
// Master drives the config/AXIS-cfg signals; slave (serializer) returns dac_ready.
interface ad5791_cfg_sequencer_if;
    logic        configuration_mode;
    logic [2:0]  configuration_axis;
    logic        configuration_send;
    logic [31:0] cfg_tdata;
    logic        cfg_tvalid;
    logic        dac_ready;

    modport master (
        output configuration_mode,
        output configuration_axis,
        output configuration_send,
        output cfg_tdata,
        output cfg_tvalid,
        input  dac_ready
    );

    modport slave (
        input  configuration_mode,
        input  configuration_axis,
        input  configuration_send,
        input  cfg_tdata,
        input  cfg_tvalid,
        output dac_ready
    );
endinterface

// File: rtl/ad5791_cfg_sequencer.sv
// Power-up / host register-write sequencer for the 4-channel AD5791 serializer.
// Latency: one word per cycle in LOAD, frame waits on dac_ready; host held off until STREAM.
module ad5791_cfg_sequencer #(
    parameter int                        NUM_DAC        = 4,
    parameter int                        DAC_WORD_WIDTH = 24,
    parameter logic [DAC_WORD_WIDTH-1:0] CTRL_WORD      = 24'h200012,
    parameter logic [DAC_WORD_WIDTH-1:0] ZERO_WORD      = 24'h100000,
    parameter int                        SETTLE_CYCLES  = 256,
    parameter int                        START_TIMEOUT  = 64,
    parameter int                        DONE_TIMEOUT   = 1024
) (
    input  logic                      a_clk,
    input  logic                      a_resetn,
    input  logic                      start,
    input  logic                      host_req,
    input  logic [1:0]                host_axis,
    input  logic [DAC_WORD_WIDTH-1:0] host_word,
    output logic                      host_ack,
    ad5791_cfg_sequencer_if.master    sif,
    output logic                      busy,
    output logic                      init_done,
    output logic                      error,
    output logic [3:0]                state_mon
);

    typedef enum logic [3:0] {
        RST_WAIT   = 4'd0,
        LOAD       = 4'd1,
        ARM        = 4'd2,
        WAIT_START = 4'd3,
        WAIT_DONE  = 4'd4,
        SETTLE     = 4'd5,
        STREAM     = 4'd6,
        ERROR      = 4'd7
    } state_t;

    typedef enum logic [1:0] {
        PH_CTRL = 2'd0,
        PH_ZERO = 2'd1,
        PH_HOST = 2'd2
    } phase_t;

    localparam logic [15:0] RDY_LIM    = 16'd15;
    localparam logic [15:0] START_LIM  = 16'(START_TIMEOUT - 1);
    localparam logic [15:0] DONE_LIM   = 16'(DONE_TIMEOUT - 1);
    localparam logic [15:0] SETTLE_LIM = 16'(SETTLE_CYCLES - 1);

    state_t                    state;
    phase_t                    phase;
    logic                      rdy_q;
    logic [2:0]                idx;
    logic [15:0]               timer;
    logic [15:0]               timer_inc;
    logic                      start_pend;
    logic [1:0]                host_axis_q;
    logic [DAC_WORD_WIDTH-1:0] host_word_q;
    logic [DAC_WORD_WIDTH-1:0] load_word;
    logic [1:0]                load_axis;
    logic [2:0]                load_cnt;

    assign timer_inc = (timer == 16'hFFFF) ? timer : timer + 16'd1;
    assign load_word = (phase == PH_CTRL) ? CTRL_WORD :
                       (phase == PH_ZERO) ? ZERO_WORD : host_word_q;
    assign load_axis = (phase == PH_HOST) ? host_axis_q : idx[1:0];
    assign load_cnt  = (phase == PH_HOST) ? 3'd1 : 3'(NUM_DAC);

    assign busy      = (state != STREAM) && (state != ERROR);
    assign state_mon = state;

    always_ff @(posedge a_clk or negedge a_resetn) begin
        if (!a_resetn) begin
            rdy_q <= 1'b0;
        end else begin
            rdy_q <= sif.dac_ready;
        end
    end

    always_ff @(posedge a_clk or negedge a_resetn) begin
        if (!a_resetn) begin
            state                  <= RST_WAIT;
            phase                  <= PH_CTRL;
            idx                    <= 3'd0;
            timer                  <= 16'd0;
            start_pend             <= 1'b0;
            host_axis_q            <= 2'd0;
            host_word_q            <= '0;
            host_ack               <= 1'b0;
            init_done              <= 1'b0;
            error                  <= 1'b0;
            sif.configuration_mode <= 1'b0;
            sif.configuration_axis <= 3'd0;
            sif.configuration_send <= 1'b0;
            sif.cfg_tdata          <= 32'd0;
            sif.cfg_tvalid         <= 1'b0;
        end else begin
            host_ack <= 1'b0;

            // A start outside STREAM is remembered and served on the next STREAM entry.
            if (start && state != STREAM && state != ERROR) begin
                start_pend <= 1'b1;
                init_done  <= 1'b0;
            end

            case (state)
                RST_WAIT: begin
                    if (!rdy_q) begin
                        timer <= 16'd0;
                    end else if (timer == RDY_LIM) begin
                        timer                  <= 16'd0;
                        phase                  <= PH_CTRL;
                        idx                    <= 3'd0;
                        sif.configuration_mode <= 1'b1;
                        state                  <= LOAD;
                    end else begin
                        timer <= timer_inc;
                    end
                end

                LOAD: begin
                    if (idx < load_cnt) begin
                        sif.cfg_tvalid         <= 1'b1;
                        sif.configuration_axis <= {1'b0, load_axis};
                        sif.cfg_tdata          <= 32'(load_word);
                        idx                    <= idx + 3'd1;
                    end else begin
                        sif.cfg_tvalid         <= 1'b0;
                        sif.configuration_axis <= 3'd0;
                        sif.cfg_tdata          <= 32'd0;
                        state                  <= ARM;
                    end
                end

                ARM: begin
                    sif.configuration_send <= 1'b1;
                    timer                  <= 16'd0;
                    state                  <= WAIT_START;
                end

                WAIT_START: begin
                    // No ready drop means the serializer saw an unchanged word: frame skipped.
                    if (!rdy_q) begin
                        sif.configuration_send <= 1'b0;
                        timer                  <= 16'd0;
                        state                  <= WAIT_DONE;
                    end else if (timer == START_LIM) begin
                        sif.configuration_send <= 1'b0;
                        timer                  <= 16'd0;
                        state                  <= SETTLE;
                    end else begin
                        timer <= timer_inc;
                    end
                end

                WAIT_DONE: begin
                    if (rdy_q) begin
                        timer <= 16'd0;
                        state <= SETTLE;
                    end else if (timer == DONE_LIM) begin
                        sif.configuration_mode <= 1'b0;
                        error                  <= 1'b1;
                        state                  <= ERROR;
                    end else begin
                        timer <= timer_inc;
                    end
                end

                SETTLE: begin
                    if (timer == SETTLE_LIM) begin
                        timer <= 16'd0;
                        case (phase)
                            PH_CTRL: begin
                                phase <= PH_ZERO;
                                idx   <= 3'd0;
                                state <= LOAD;
                            end
                            PH_ZERO: begin
                                init_done              <= ~(start_pend | start);
                                sif.configuration_mode <= 1'b0;
                                state                  <= STREAM;
                            end
                            default: begin
                                host_ack               <= 1'b1;
                                sif.configuration_mode <= 1'b0;
                                state                  <= STREAM;
                            end
                        endcase
                    end else begin
                        timer <= timer_inc;
                    end
                end

                STREAM: begin
                    if (start || start_pend) begin
                        start_pend             <= 1'b0;
                        init_done              <= 1'b0;
                        phase                  <= PH_CTRL;
                        idx                    <= 3'd0;
                        sif.configuration_mode <= 1'b1;
                        state                  <= LOAD;
                    end else if (host_req) begin
                        host_axis_q            <= host_axis;
                        host_word_q            <= host_word;
                        phase                  <= PH_HOST;
                        idx                    <= 3'd0;
                        sif.configuration_mode <= 1'b1;
                        state                  <= LOAD;
                    end
                end

                ERROR: begin
                    if (start) begin
                        error      <= 1'b0;
                        init_done  <= 1'b0;
                        start_pend <= 1'b0;
                        timer      <= 16'd0;
                        state      <= RST_WAIT;
                    end
                end

                default: begin
                    state <= RST_WAIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ad5791_cfg_sequencer.sv
// Scoreboard bench for ad5791_cfg_sequencer with a behavioural serializer ready model.
// Expected config words / sends / acks / errors are queued by stimulus and popped by a monitor.
module tb_ad5791_cfg_sequencer;

    localparam int EV_WORD = 0;
    localparam int EV_SEND = 1;
    localparam int EV_ACK  = 2;
    localparam int EV_ERR  = 3;

    typedef struct {
        int          kind;
        logic [2:0]  axis;
        logic [31:0] data;
    } ev_t;

    logic        a_clk = 1'b0;
    logic        a_resetn;
    logic        start;
    logic        host_req;
    logic [1:0]  host_axis;
    logic [23:0] host_word;
    logic        host_ack;
    logic        busy;
    logic        init_done;
    logic        error;
    logic [3:0]  state_mon;

    ad5791_cfg_sequencer_if sif();

    ad5791_cfg_sequencer dut (
        .a_clk     (a_clk),
        .a_resetn  (a_resetn),
        .start     (start),
        .host_req  (host_req),
        .host_axis (host_axis),
        .host_word (host_word),
        .host_ack  (host_ack),
        .sif       (sif),
        .busy      (busy),
        .init_done (init_done),
        .error     (error),
        .state_mon (state_mon)
    );

    always #4 a_clk = ~a_clk;

    int   total = 0;
    int   bad   = 0;
    ev_t  exp_q[$];

    // Serializer model: 0 = normal frame, 1 = never drops ready, 2 = ready stuck low.
    int   ser_mode     = 0;
    int   busy_cnt     = 0;
    int   rdy_high_cnt = 0;
    logic send_prev_m  = 1'b0;

    initial begin
        sif.dac_ready = 1'b1;
        forever begin
            @(negedge a_clk);
            if (busy_cnt > 0) begin
                busy_cnt--;
            end else if (sif.configuration_send && !send_prev_m && ser_mode != 1) begin
                sif.dac_ready = 1'b0;
                busy_cnt      = 216;
            end else if (ser_mode != 2) begin
                sif.dac_ready = 1'b1;
            end
            send_prev_m  = sif.configuration_send;
            rdy_high_cnt = sif.dac_ready ? rdy_high_cnt + 1 : 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_ev(input int kind, input logic [2:0] axis, input logic [31:0] data);
        ev_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event: kind=%0d axis=%0d data=0x%08h with nothing expected",
                     kind, axis, data);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || (kind == EV_WORD && (e.axis !== axis || e.data !== data))) begin
                bad++;
                $display("FAIL event: got kind=%0d axis=%0d data=0x%08h expected kind=%0d axis=%0d data=0x%08h",
                         kind, axis, data, e.kind, e.axis, e.data);
            end
        end
    endtask

    task automatic push_ev(input int kind, input logic [2:0] axis, input logic [31:0] data);
        ev_t e;
        e.kind = kind;
        e.axis = axis;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic push_init();
        for (int i = 0; i < 4; i++) push_ev(EV_WORD, 3'(i), 32'h0020_0012);
        push_ev(EV_SEND, 3'd0, 32'd0);
        for (int i = 0; i < 4; i++) push_ev(EV_WORD, 3'(i), 32'h0010_0000);
        push_ev(EV_SEND, 3'd0, 32'd0);
    endtask

    task automatic wait_state(input logic [3:0] s, input int budget, input string name);
        int n;
        n = 0;
        while (state_mon !== s && n < budget) begin
            @(negedge a_clk);
            n++;
        end
        total++;
        if (state_mon !== s) begin
            bad++;
            $display("FAIL %s: state_mon=%0d, required %0d within %0d cycles", name, state_mon, s, budget);
        end
    endtask

    task automatic wait_ack(input int budget, input string name);
        int n;
        n = 0;
        while (host_ack !== 1'b1 && n < budget) begin
            @(negedge a_clk);
            n++;
        end
        total++;
        if (host_ack !== 1'b1) begin
            bad++;
            $display("FAIL %s: host_ack=%b, required 1 within %0d cycles", name, host_ack, budget);
        end
    endtask

    // Monitor: pops the scoreboard on every observable DUT event.
    logic send_p = 1'b0, err_p = 1'b0, tv_p = 1'b0, mode_p = 1'b0;
    int   send_len = 0;
    int   last_send_len = 0;

    initial begin
        forever begin
            @(negedge a_clk);
            if (!a_resetn) begin
                send_p   = 1'b0;
                err_p    = 1'b0;
                tv_p     = 1'b0;
                mode_p   = 1'b0;
                send_len = 0;
            end else begin
                if (sif.cfg_tvalid) begin
                    if (!tv_p) chk("mode_lead", 32'(mode_p), 32'd1);
                    check_ev(EV_WORD, sif.configuration_axis, sif.cfg_tdata);
                end
                if (sif.configuration_send && !send_p) check_ev(EV_SEND, 3'd0, 32'd0);
                if (host_ack) check_ev(EV_ACK, 3'd0, 32'd0);
                if (error && !err_p) check_ev(EV_ERR, 3'd0, 32'd0);
                if (sif.configuration_send) begin
                    send_len++;
                end else begin
                    if (send_len > 0) last_send_len = send_len;
                    send_len = 0;
                end
                send_p = sif.configuration_send;
                err_p  = error;
                tv_p   = sif.cfg_tvalid;
                mode_p = sif.configuration_mode;
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        a_resetn  = 1'b0;
        start     = 1'b0;
        host_req  = 1'b0;
        host_axis = 2'd0;
        host_word = 24'd0;
        repeat (3) @(negedge a_clk);

        chk("rst_mode",   32'(sif.configuration_mode), 32'd0);
        chk("rst_send",   32'(sif.configuration_send), 32'd0);
        chk("rst_tvalid", 32'(sif.cfg_tvalid), 32'd0);
        chk("rst_tdata",  sif.cfg_tdata, 32'd0);
        chk("rst_axis",   32'(sif.configuration_axis), 32'd0);
        chk("rst_ack",    32'(host_ack), 32'd0);
        chk("rst_busy",   32'(busy), 32'd1);
        chk("rst_done",   32'(init_done), 32'd0);
        chk("rst_error",  32'(error), 32'd0);
        chk("rst_state",  32'(state_mon), 32'd0);

        // Power-up sequence after reset release.
        push_init();
        a_resetn = 1'b1;
        wait_state(4'd6, 4000, "init_stream");
        chk("init_done", 32'(init_done), 32'd1);
        chk("init_mode", 32'(sif.configuration_mode), 32'd0);
        chk("init_busy", 32'(busy), 32'd0);
        @(negedge a_clk);
        chk("init_q_empty", 32'(exp_q.size()), 32'd0);

        // Single host write from STREAM.
        push_ev(EV_WORD, 3'd2, 32'h001A_BCDE);
        push_ev(EV_SEND, 3'd0, 32'd0);
        push_ev(EV_ACK,  3'd0, 32'd0);
        host_axis = 2'd2;
        host_word = 24'h1ABCDE;
        host_req  = 1'b1;
        wait_ack(2000, "host_ack");
        host_req = 1'b0;
        @(negedge a_clk);
        chk("host_mode", 32'(sif.configuration_mode), 32'd0);
        chk("host_state", 32'(state_mon), 32'd6);
        chk("host_q_empty", 32'(exp_q.size()), 32'd0);

        // Host request raised during a restarted init must wait for init to finish.
        push_init();
        push_ev(EV_WORD, 3'd1, 32'h000F_0F0F);
        push_ev(EV_SEND, 3'd0, 32'd0);
        push_ev(EV_ACK,  3'd0, 32'd0);
        start = 1'b1;
        @(negedge a_clk);
        start = 1'b0;
        chk("start_clears_done", 32'(init_done), 32'd0);
        chk("start_busy", 32'(busy), 32'd1);
        repeat (5) @(negedge a_clk);
        host_axis = 2'd1;
        host_word = 24'h0F0F0F;
        host_req  = 1'b1;
        wait_ack(4000, "pend_host_ack");
        chk("done_before_host_ack", 32'(init_done), 32'd1);
        host_req = 1'b0;
        @(negedge a_clk);
        chk("pend_q_empty", 32'(exp_q.size()), 32'd0);

        // Serializer ignores the frame: send times out, frame is skipped.
        ser_mode = 1;
        push_ev(EV_WORD, 3'd3, 32'h0000_0001);
        push_ev(EV_SEND, 3'd0, 32'd0);
        push_ev(EV_ACK,  3'd0, 32'd0);
        host_axis = 2'd3;
        host_word = 24'h000001;
        host_req  = 1'b1;
        wait_ack(2000, "skip_ack");
        host_req = 1'b0;
        ser_mode = 0;
        @(negedge a_clk);
        chk("skip_send_len", 32'(last_send_len), 32'd64);
        chk("skip_no_error", 32'(error), 32'd0);
        chk("skip_q_empty", 32'(exp_q.size()), 32'd0);

        // Ready stuck low: DONE timeout into ERROR.
        ser_mode = 2;
        push_ev(EV_WORD, 3'd0, 32'h0005_5555);
        push_ev(EV_SEND, 3'd0, 32'd0);
        push_ev(EV_ERR,  3'd0, 32'd0);
        host_axis = 2'd0;
        host_word = 24'h055555;
        host_req  = 1'b1;
        wait_state(4'd7, 3000, "error_state");
        host_req = 1'b0;
        @(negedge a_clk);
        chk("err_flag",   32'(error), 32'd1);
        chk("err_mode",   32'(sif.configuration_mode), 32'd0);
        chk("err_send",   32'(sif.configuration_send), 32'd0);
        chk("err_tvalid", 32'(sif.cfg_tvalid), 32'd0);
        chk("err_tdata",  sif.cfg_tdata, 32'd0);
        chk("err_axis",   32'(sif.configuration_axis), 32'd0);
        chk("err_busy",   32'(busy), 32'd0);
        chk("err_q_empty", 32'(exp_q.size()), 32'd0);

        // Start from ERROR reruns the whole init.
        ser_mode = 0;
        repeat (2) @(negedge a_clk);
        push_init();
        start = 1'b1;
        @(negedge a_clk);
        start = 1'b0;
        chk("restart_state", 32'(state_mon), 32'd0);
        chk("restart_error", 32'(error), 32'd0);
        wait_state(4'd6, 4000, "restart_stream");
        chk("restart_done", 32'(init_done), 32'd1);
        @(negedge a_clk);
        chk("restart_q_empty", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset in the middle of WAIT_DONE.
        push_ev(EV_WORD, 3'd1, 32'h000A_0A0A);
        push_ev(EV_SEND, 3'd0, 32'd0);
        host_axis = 2'd1;
        host_word = 24'h0A0A0A;
        host_req  = 1'b1;
        wait_state(4'd4, 2000, "wd_reach");
        repeat (20) @(negedge a_clk);
        #1 a_resetn = 1'b0;
        #1;
        chk("arst_mode",  32'(sif.configuration_mode), 32'd0);
        chk("arst_send",  32'(sif.configuration_send), 32'd0);
        chk("arst_state", 32'(state_mon), 32'd0);
        chk("arst_busy",  32'(busy), 32'd1);
        host_req = 1'b0;
        chk("arst_q_empty", 32'(exp_q.size()), 32'd0);
        repeat (5) @(negedge a_clk);
        push_init();
        a_resetn = 1'b1;
        n = 0;
        while (sif.configuration_mode !== 1'b1 && n < 2000) begin
            @(negedge a_clk);
            #1;
            n++;
        end
        chk("arst_load_after_ready", 32'(sif.configuration_mode), 32'd1);
        total++;
        if (rdy_high_cnt < 18) begin
            bad++;
            $display("FAIL arst_ready_wait: ready high for %0d cycles before LOAD, required at least 18",
                     rdy_high_cnt);
        end
        wait_state(4'd6, 4000, "arst_stream");
        chk("arst_done", 32'(init_done), 32'd1);
        @(negedge a_clk);
        chk("arst_final_q_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
